// File: rtl/seq_pkg.sv
// Shared state encoding for the serial sequence family (generators and detectors).
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first for a number
// of repetitions, with FILL bits between repetitions. Outputs decode registered state only.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int   PAT_W = 3,
  parameter int   CNT_W = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             sout,
  output logic             sout_valid,
  output logic             pat_end,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Counters stop at 1 rather than wrapping, so all-ones reps/gap are safe.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reps != '0) begin
            pat_d   = pattern;
            rem_d   = reps;
            gap_d   = gap;
            idx_d   = IDX_TOP;
            state_d = ST_SEND;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_ONE;
        end else if (rem_q == CNT_ONE) begin
          rem_d   = '0;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - CNT_ONE;
          if (gap_q == '0) begin
            idx_d = IDX_TOP;
          end else begin
            gcnt_d  = gap_q;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == CNT_ONE) begin
          gcnt_d  = '0;
          idx_d   = IDX_TOP;
          state_d = ST_SEND;
        end else begin
          gcnt_d = gcnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    pat_end    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_SEND: begin
        sout       = pat_q[idx_q];
        sout_valid = 1'b1;
        pat_end    = (idx_q == '0);
        busy       = 1'b1;
      end
      ST_GAP: begin
        sout       = FILL;
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with a tiny overlapping 101 detector on sout.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] pattern;
  logic [7:0] reps;
  logic [7:0] gap;
  logic       sout, sout_valid, pat_end, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  seq_pattern_gen #(.PAT_W(3), .CNT_W(8), .FILL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .reps       (reps),
    .gap        (gap),
    .sout       (sout),
    .sout_valid (sout_valid),
    .pat_end    (pat_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Running totals sampled mid-cycle; jobs are measured as differences.
  int          n_valid = 0, n_pe = 0, n_done = 0, n_busy = 0, n_match = 0;
  logic [63:0] bits = '0, pem = '0;
  logic [1:0]  det = 2'b00;

  always @(negedge clk) begin
    if (sout_valid) begin
      n_valid <= n_valid + 1;
      bits    <= {bits[62:0], sout};
      pem     <= {pem[62:0], pat_end};
      if (det == 2'b10 && sout) n_match <= n_match + 1;
      det     <= {det[0], sout};
    end else begin
      det <= 2'b00;
    end
    if (pat_end) n_pe   <= n_pe + 1;
    if (done)    n_done <= n_done + 1;
    if (busy)    n_busy <= n_busy + 1;
  end

  int b_valid, b_pe, b_done, b_busy, b_match;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_pe    = n_pe;
    b_done  = n_done;
    b_busy  = n_busy;
    b_match = n_match;
  endtask

  task automatic start_job(input logic [2:0] p, input logic [7:0] r, input logic [7:0] g);
    @(posedge clk); #1;
    pattern = p;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Counts mid-cycle samples until done is seen; budget expiry yields budget+1.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!done && n <= budget);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
    #1;
    chk("rst_outs", {sout, sout_valid, pat_end, busy, done}, 5'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: 101 x3, no gap
    snap();
    start_job(3'b101, 8'd3, 8'd0);
    wait_done(40, cyc);
    chk("t1_done_cyc", cyc, 10);
    chk("t1_valid", n_valid - b_valid, 9);
    chk("t1_bits", bits[8:0], 9'b101101101);
    chk("t1_pat_end", pem[8:0], 9'b001001001);
    chk("t1_busy", n_busy - b_busy, 9);
    chk("t1_done_n", n_done - b_done, 1);
    chk("t1_done_outs", {sout_valid, busy}, 2'b00);

    // 2: 101 x3 with one fill bit; overlapping detector sees 5 matches
    snap();
    start_job(3'b101, 8'd3, 8'd1);
    wait_done(40, cyc);
    chk("t2_done_cyc", cyc, 12);
    chk("t2_bits", bits[10:0], 11'b10101010101);
    chk("t2_pat_end", pem[10:0], 11'b00100010001);
    chk("t2_pe_n", n_pe - b_pe, 3);
    chk("t2_match_n", n_match - b_match, 5);

    // 3: zero repetitions
    snap();
    start_job(3'b111, 8'd0, 8'd2);
    wait_done(10, cyc);
    chk("t3_done_cyc", cyc, 1);
    chk("t3_valid", n_valid - b_valid, 0);
    chk("t3_busy", n_busy - b_busy, 0);

    // 4: start and pattern change mid-job are ignored
    snap();
    start_job(3'b110, 8'd2, 8'd0);
    @(posedge clk); #1;
    pattern = 3'b011;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done(40, cyc);
    chk("t4_done_cyc", cyc, 5);
    chk("t4_bits", bits[5:0], 6'b110110);
    chk("t4_valid", n_valid - b_valid, 6);
    chk("t4_done_n", n_done - b_done, 1);
    snap();
    start_job(3'b011, 8'd2, 8'd0);
    wait_done(40, cyc);
    chk("t4b_bits", bits[5:0], 6'b011011);
    chk("t4b_valid", n_valid - b_valid, 6);

    // 5: async reset while in GAP
    start_job(3'b101, 8'd2, 8'd3);
    repeat (3) @(posedge clk);
    #2;
    chk("t5_in_gap", {sout_valid, busy, pat_end}, 3'b110);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {sout, sout_valid, pat_end, busy, done}, 5'b0);
    snap();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_no_done", n_done - b_done, 0);
    snap();
    start_job(3'b110, 8'd1, 8'd0);
    wait_done(20, cyc);
    chk("t5_fresh_cyc", cyc, 4);
    chk("t5_fresh_bits", bits[2:0], 3'b110);
    chk("t5_fresh_valid", n_valid - b_valid, 3);

    // 6: counter limits
    snap();
    start_job(3'b111, 8'd255, 8'd255);
    wait_done(70000, cyc);
    chk("t6_done_cyc", cyc, 255*3 + 254*255 + 1);
    chk("t6_valid", n_valid - b_valid, 255*3 + 254*255);
    chk("t6_pe_n", n_pe - b_pe, 255);
    chk("t6_done_n", n_done - b_done, 1);
    @(negedge clk); #1;
    chk("t6_idle", {done, busy, sout_valid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
